// File: rtl/q1q2_gap_pkg.sv
// Shared definitions for the q1 ##[MIN:MAX] q2 gap checker.
//   state_e : per-channel sequence-tracking state
//   STAT_W  : width of the optional per-channel pass/fail counters
//   sat_inc : increment that holds at a caller-supplied ceiling
package q1q2_gap_pkg;

  typedef enum logic [1:0] {IDLE, SAW_A, ARMED, SAW_C} state_e;

  localparam int STAT_W = 16;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return (v >= max) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/q1q2_gap_checker_if.sv
// Bundle of per-channel sequence terms and checker results.
//   en, a, b, c, d            : N_CH-wide stimulus/enable, driven by the master
//   pass, err_early, err_tmo  : N_CH-wide one-cycle result pulses
//   gap_out                   : N_CH*CNT_W last measured gap per channel
//   busy                      : N_CH-wide, channel is tracking a sequence
interface q1q2_gap_checker_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
);
  logic [N_CH-1:0]       en;
  logic [N_CH-1:0]       a;
  logic [N_CH-1:0]       b;
  logic [N_CH-1:0]       c;
  logic [N_CH-1:0]       d;
  logic [N_CH-1:0]       pass;
  logic [N_CH-1:0]       err_early;
  logic [N_CH-1:0]       err_tmo;
  logic [N_CH*CNT_W-1:0] gap_out;
  logic [N_CH-1:0]       busy;

  modport master (output en, a, b, c, d,
                  input  pass, err_early, err_tmo, gap_out, busy);
  modport slave  (input  en, a, b, c, d,
                  output pass, err_early, err_tmo, gap_out, busy);
endinterface

// File: rtl/q1q2_gap_chan.sv
// One channel of the gap checker: tracks q1 (a ##1 b), counts cycles from the
// b sample, then tracks q2 (c ##1 d) and classifies the gap.
// Ports: clk, rst (async, active-high), en, a, b, c, d in;
//        pass, err_early, err_tmo (registered pulses), gap_out, busy out.
// Optional macro Q1Q2_GAP_STATS_EN adds stats_clr in and pass_cnt/fail_cnt out.
module q1q2_gap_chan
  import q1q2_gap_pkg::*;
#(
  parameter int MIN_GAP = 5,
  parameter int MAX_GAP = 10,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  output logic             pass,
  output logic             err_early,
  output logic             err_tmo,
  output logic [CNT_W-1:0] gap_out,
`ifdef Q1Q2_GAP_STATS_EN
  input  logic              stats_clr,
  output logic [STAT_W-1:0] pass_cnt,
  output logic [STAT_W-1:0] fail_cnt,
`endif
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_ALL = '1;
  localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_GAP);
  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_GAP);
  localparam bit               TMO_EN  = (MAX_GAP != 0);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [CNT_W-1:0] gap, gap_nxt, gap_out_nxt;
  logic             pass_nxt, early_nxt, tmo_nxt;

  assign cnt_inc = CNT_W'(sat_inc(32'(cnt), 32'(CNT_ALL)));
  assign busy    = (state != IDLE);

  // Next-state decision from the current edge's samples
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    gap_nxt     = gap;
    gap_out_nxt = gap_out;
    pass_nxt    = 1'b0;
    early_nxt   = 1'b0;
    tmo_nxt     = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: if (a) state_nxt = SAW_A;
        SAW_A: begin
          if (b) begin
            state_nxt = ARMED;
            cnt_nxt   = CNT_W'(1);
          end else if (!a) begin
            state_nxt = IDLE;
          end
        end
        // cnt keeps running through SAW_C so a retried c still measures from b
        ARMED: begin
          if (c) begin
            state_nxt = SAW_C;
            gap_nxt   = cnt;
            cnt_nxt   = cnt_inc;
          end else if (TMO_EN && cnt >= MAX_C) begin
            tmo_nxt   = 1'b1;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        SAW_C: begin
          if (d) begin
            state_nxt = IDLE;
            if (gap < MIN_C) begin
              early_nxt   = 1'b1;
              gap_out_nxt = gap;
            end else if (TMO_EN && gap > MAX_C) begin
              // c arrived after the window closed: a late q2 is a timeout, not a pass
              tmo_nxt = 1'b1;
            end else begin
              pass_nxt    = 1'b1;
              gap_out_nxt = gap;
            end
          end else if (TMO_EN && gap >= MAX_C) begin
            tmo_nxt   = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = ARMED;
            cnt_nxt   = cnt_inc;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State and registered result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      gap       <= '0;
      gap_out   <= '0;
      pass      <= 1'b0;
      err_early <= 1'b0;
      err_tmo   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      gap       <= gap_nxt;
      gap_out   <= gap_out_nxt;
      pass      <= pass_nxt;
      err_early <= early_nxt;
      err_tmo   <= tmo_nxt;
    end
  end

`ifdef Q1Q2_GAP_STATS_EN
  localparam logic [STAT_W-1:0] STAT_ALL = '1;

  // Counters advance on the same edge that raises the pulse; clear wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else if (stats_clr) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else begin
      if (pass_nxt)
        pass_cnt <= STAT_W'(sat_inc(32'(pass_cnt), 32'(STAT_ALL)));
      if (early_nxt || tmo_nxt)
        fail_cnt <= STAT_W'(sat_inc(32'(fail_cnt), 32'(STAT_ALL)));
    end
  end
`endif

endmodule

// File: rtl/q1q2_gap_checker.sv
// Multi-channel q1 ##[MIN_GAP:MAX_GAP] q2 monitor; one independent channel per bit.
// Ports: clk, rst (async, active-high), bus (q1q2_gap_checker_if.slave: en/a/b/c/d in,
//        pass/err_early/err_tmo/gap_out/busy out).
// Optional macro Q1Q2_GAP_STATS_EN adds stats_clr in and pass_cnt/fail_cnt
// (N_CH*STAT_W) saturating per-channel counters.
module q1q2_gap_checker
  import q1q2_gap_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int MIN_GAP = 5,
  parameter int MAX_GAP = 10,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst,
`ifdef Q1Q2_GAP_STATS_EN
  input  logic                   stats_clr,
  output logic [N_CH*STAT_W-1:0] pass_cnt,
  output logic [N_CH*STAT_W-1:0] fail_cnt,
`endif
  q1q2_gap_checker_if.slave bus
);

  logic [N_CH-1:0]       pass_v, early_v, tmo_v, busy_v;
  logic [N_CH*CNT_W-1:0] gap_v;

  assign bus.pass      = pass_v;
  assign bus.err_early = early_v;
  assign bus.err_tmo   = tmo_v;
  assign bus.busy      = busy_v;
  assign bus.gap_out   = gap_v;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    q1q2_gap_chan #(
      .MIN_GAP (MIN_GAP),
      .MAX_GAP (MAX_GAP),
      .CNT_W   (CNT_W)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .en        (bus.en[i]),
      .a         (bus.a[i]),
      .b         (bus.b[i]),
      .c         (bus.c[i]),
      .d         (bus.d[i]),
      .pass      (pass_v[i]),
      .err_early (early_v[i]),
      .err_tmo   (tmo_v[i]),
      .gap_out   (gap_v[i*CNT_W +: CNT_W]),
`ifdef Q1Q2_GAP_STATS_EN
      .stats_clr (stats_clr),
      .pass_cnt  (pass_cnt[i*STAT_W +: STAT_W]),
      .fail_cnt  (fail_cnt[i*STAT_W +: STAT_W]),
`endif
      .busy      (busy_v[i])
    );
  end

endmodule

// File: tb/tb_q1q2_gap_checker.sv
// Directed bench for q1q2_gap_checker (MIN_GAP=5, MAX_GAP=10, 4 channels).
// Edge n in the comments is the n-th posedge of a scenario; inputs are set
// just after the previous edge and outputs observed 1 time unit after edge n.
module tb_q1q2_gap_checker;

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  q1q2_gap_checker_if #(.N_CH(4), .CNT_W(8)) bus();

`ifdef Q1Q2_GAP_STATS_EN
  logic        stats_clr;
  logic [63:0] pass_cnt, fail_cnt;
`endif

  q1q2_gap_checker #(
    .N_CH(4), .MIN_GAP(5), .MAX_GAP(10), .CNT_W(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef Q1Q2_GAP_STATS_EN
    .stats_clr (stats_clr),
    .pass_cnt  (pass_cnt),
    .fail_cnt  (fail_cnt),
`endif
    .bus       (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one edge worth of a/b/c/d, then return them to 0
  task automatic drv(input logic [3:0] av, input logic [3:0] bv,
                     input logic [3:0] cv, input logic [3:0] dv);
    bus.a = av; bus.b = bv; bus.c = cv; bus.d = dv;
    tick();
    bus.a = '0; bus.b = '0; bus.c = '0; bus.d = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(4'h0, 4'h0, 4'h0, 4'h0);
  endtask

  initial begin
    rst = 1'b1;
    bus.en = 4'hF;
    bus.a = '0; bus.b = '0; bus.c = '0; bus.d = '0;
`ifdef Q1Q2_GAP_STATS_EN
    stats_clr = 1'b0;
`endif
    tick(); tick();
    chk("rst_pass",  32'(bus.pass),      32'h0);
    chk("rst_early", 32'(bus.err_early), 32'h0);
    chk("rst_tmo",   32'(bus.err_tmo),   32'h0);
    chk("rst_gap",   bus.gap_out,        32'h0);
    chk("rst_busy",  32'(bus.busy),      32'h0);
    rst = 1'b0;
    idle(1);

    // Scenario 1: a@1 b@2 c@7 d@8 -> pass, gap 5
    drv(4'h1, 4'h0, 4'h0, 4'h0);
    drv(4'h0, 4'h1, 4'h0, 4'h0);
    chk("s1_busy_armed", 32'(bus.busy), 32'h1);
    idle(4);
    drv(4'h0, 4'h0, 4'h1, 4'h0);
    chk("s1_no_pass_at_c", 32'(bus.pass), 32'h0);
    drv(4'h0, 4'h0, 4'h0, 4'h1);
    chk("s1_pass",  32'(bus.pass),       32'h1);
    chk("s1_early", 32'(bus.err_early),  32'h0);
    chk("s1_gap",   32'(bus.gap_out[7:0]), 32'd5);
    chk("s1_busy",  32'(bus.busy),       32'h0);
    idle(1);
    chk("s1_pulse_width", 32'(bus.pass), 32'h0);

    // Scenario 2: a@1 b@2 c@5 d@6 -> err_early, gap 3
    drv(4'h1, 4'h0, 4'h0, 4'h0);
    drv(4'h0, 4'h1, 4'h0, 4'h0);
    idle(2);
    drv(4'h0, 4'h0, 4'h1, 4'h0);
    drv(4'h0, 4'h0, 4'h0, 4'h1);
    chk("s2_early", 32'(bus.err_early),  32'h1);
    chk("s2_pass",  32'(bus.pass),       32'h0);
    chk("s2_gap",   32'(bus.gap_out[7:0]), 32'd3);
    idle(1);

    // Scenario 3a: a@1 b@2, no c -> err_tmo after edge 12
    drv(4'h1, 4'h0, 4'h0, 4'h0);
    drv(4'h0, 4'h1, 4'h0, 4'h0);
    idle(9);
    chk("s3_tmo_e11",  32'(bus.err_tmo), 32'h0);
    chk("s3_busy_e11", 32'(bus.busy),    32'h1);
    idle(1);
    chk("s3_tmo",      32'(bus.err_tmo), 32'h1);
    chk("s3_busy_e12", 32'(bus.busy),    32'h0);
    chk("s3_gap_held", 32'(bus.gap_out[7:0]), 32'd3);
    idle(1);

    // Scenario 3b: c@12 d@13 -> pass at the upper boundary, gap 10
    drv(4'h1, 4'h0, 4'h0, 4'h0);
    drv(4'h0, 4'h1, 4'h0, 4'h0);
    idle(9);
    drv(4'h0, 4'h0, 4'h1, 4'h0);
    chk("s3b_no_tmo", 32'(bus.err_tmo), 32'h0);
    drv(4'h0, 4'h0, 4'h0, 4'h1);
    chk("s3b_pass", 32'(bus.pass),       32'h1);
    chk("s3b_gap",  32'(bus.gap_out[7:0]), 32'd10);
    idle(1);

    // Scenario 4: a@4 b@5 ignored; c@7 no d@8; c@9 d@10 -> pass, gap 7
    drv(4'h1, 4'h0, 4'h0, 4'h0);
    drv(4'h0, 4'h1, 4'h0, 4'h0);
    idle(1);
    drv(4'h1, 4'h0, 4'h0, 4'h0);
    drv(4'h0, 4'h1, 4'h0, 4'h0);
    idle(1);
    drv(4'h0, 4'h0, 4'h1, 4'h0);
    idle(1);
    chk("s4_no_pulse_e8", 32'(bus.pass | bus.err_early | bus.err_tmo), 32'h0);
    chk("s4_busy_e8", 32'(bus.busy), 32'h1);
    drv(4'h0, 4'h0, 4'h1, 4'h0);
    drv(4'h0, 4'h0, 4'h0, 4'h1);
    chk("s4_pass", 32'(bus.pass),       32'h1);
    chk("s4_gap",  32'(bus.gap_out[7:0]), 32'd7);
    idle(1);

    // Scenario 5a: asynchronous reset while ARMED
    drv(4'h1, 4'h0, 4'h0, 4'h0);
    drv(4'h0, 4'h1, 4'h0, 4'h0);
    idle(2);
    rst = 1'b1;
    #2;
    chk("s5_rst_busy", 32'(bus.busy), 32'h0);
    chk("s5_rst_gap",  bus.gap_out,   32'h0);
    rst = 1'b0;
    idle(10);
    chk("s5_no_pulse", 32'(bus.pass | bus.err_early | bus.err_tmo), 32'h0);
    drv(4'h1, 4'h0, 4'h0, 4'h0);
    drv(4'h0, 4'h1, 4'h0, 4'h0);
    idle(4);
    drv(4'h0, 4'h0, 4'h1, 4'h0);
    drv(4'h0, 4'h0, 4'h0, 4'h1);
    chk("s5_restart_pass", 32'(bus.pass), 32'h1);
    chk("s5_restart_gap",  32'(bus.gap_out[7:0]), 32'd5);
    idle(1);

    // Scenario 5b: en low at edge 5 abandons the sequence
    drv(4'h1, 4'h0, 4'h0, 4'h0);
    drv(4'h0, 4'h1, 4'h0, 4'h0);
    idle(2);
    bus.en = 4'hE;
    idle(1);
    chk("s5_en_busy",  32'(bus.busy), 32'h0);
    chk("s5_en_pulse", 32'(bus.pass | bus.err_early | bus.err_tmo), 32'h0);
    chk("s5_en_gap",   32'(bus.gap_out[7:0]), 32'd5);
    bus.en = 4'hF;
    drv(4'h0, 4'h0, 4'h1, 4'h0);
    drv(4'h0, 4'h0, 4'h0, 4'h1);
    chk("s5_en_no_pass", 32'(bus.pass), 32'h0);
    idle(1);

`ifdef Q1Q2_GAP_STATS_EN
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    chk("st_clr0_pass", pass_cnt, 32'h0);
`endif

    // Scenario 6: ch0 passes (gap 5) while ch1 times out
    drv(4'h3, 4'h0, 4'h0, 4'h0);
    drv(4'h0, 4'h3, 4'h0, 4'h0);
    idle(4);
    drv(4'h0, 4'h0, 4'h1, 4'h0);
    drv(4'h0, 4'h0, 4'h0, 4'h1);
    chk("s6_pass",  32'(bus.pass), 32'h1);
    chk("s6_busy",  32'(bus.busy), 32'h2);
    idle(3);
    chk("s6_tmo_e11", 32'(bus.err_tmo), 32'h0);
    idle(1);
    chk("s6_tmo",   32'(bus.err_tmo), 32'h2);
    chk("s6_pass0", 32'(bus.pass),    32'h0);
    chk("s6_gap0",  32'(bus.gap_out[7:0]), 32'd5);
`ifdef Q1Q2_GAP_STATS_EN
    chk("st_pass_ch0", 32'(pass_cnt[15:0]),  32'd1);
    chk("st_fail_ch1", 32'(fail_cnt[31:16]), 32'd1);
    chk("st_fail_ch0", 32'(fail_cnt[15:0]),  32'd0);
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    chk("st_clr_pass", 32'(pass_cnt[15:0]),  32'd0);
    chk("st_clr_fail", 32'(fail_cnt[31:16]), 32'd0);
`endif
    idle(1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
